// File: rtl/pll_pkg.sv
// Shared types and default configuration for the PLL phase-frequency detector.
package pll_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } pfd_state_t;

    localparam int unsigned PFD_SYNC_STAGES = 2;
    localparam int unsigned PFD_CNT_W       = 8;
    localparam int unsigned PFD_LOCK_WINDOW = 4;
    localparam int unsigned PFD_LOCK_COUNT  = 64;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer followed by a delay flop; flags synchronized rising edges.
module edge_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_edge_c
);

    logic [STAGES-1:0] r_sync;
    logic              r_dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_dly  <= r_sync[STAGES-1];
        end
    end

    assign o_edge_c = r_sync[STAGES-1] & ~r_dly;

endmodule

// File: rtl/pfd_tristate.sv
// Tri-state phase-frequency detector with scan chain; lock detector compiled in
// when PFD_LOCK_DETECT_EN is defined.
module pfd_tristate
    import pll_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = PFD_SYNC_STAGES,
    parameter int unsigned CNT_W       = PFD_CNT_W,
    parameter int unsigned LOCK_WINDOW = PFD_LOCK_WINDOW,
    parameter int unsigned LOCK_COUNT  = PFD_LOCK_COUNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ref_in,
    input  logic fb_in,
    output logic up,
    output logic down,
    output logic lock,
    input  logic scan_in,
    input  logic scan_en,
    output logic scan_out
);

    localparam int unsigned    CW1     = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             w_ref_edge;
    logic             w_fb_edge;
    pfd_state_t       r_state;
    logic [CNT_W-1:0] r_width_cnt;
    logic             r_up;
    logic             r_down;

    edge_sync #(.STAGES(SYNC_STAGES)) u_ref_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_d      (ref_in),
        .o_edge_c (w_ref_edge)
    );

    edge_sync #(.STAGES(SYNC_STAGES)) u_fb_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_d      (fb_in),
        .o_edge_c (w_fb_edge)
    );

    // Detector FSM and pulse-width counter; both become shift stages under scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_width_cnt <= '0;
        end else if (scan_en) begin
            r_state     <= pfd_state_t'({r_state[0], scan_in});
            r_width_cnt <= {r_width_cnt[CNT_W-2:0], r_state[1]};
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ref_edge && !w_fb_edge)      r_state <= UP;
                    else if (w_fb_edge && !w_ref_edge) r_state <= DOWN;
                end
                UP:      if (w_fb_edge)  r_state <= IDLE;
                DOWN:    if (w_ref_edge) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            if (r_state == UP || r_state == DOWN)
                r_width_cnt <= (r_width_cnt == CNT_MAX) ? CNT_MAX : r_width_cnt + CNT_W'(1);
            else
                r_width_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_up   <= 1'b0;
            r_down <= 1'b0;
        end else begin
            r_up   <= (r_state == UP);
            r_down <= (r_state == DOWN);
        end
    end

    assign up   = r_up;
    assign down = r_down;

`ifdef PFD_LOCK_DETECT_EN
    localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_COUNT);

    logic             w_compare;
    logic             w_in_window;
    logic [CW1-1:0]   w_width;
    logic [CNT_W-1:0] w_lock_inc;
    logic [CNT_W-1:0] r_lock_cnt;
    logic             r_lock;

    // Width of the pulse ending this cycle is the cycles spent in UP/DOWN so far plus this one.
    always_comb begin
        w_compare   = 1'b0;
        w_width     = CW1'(r_width_cnt) + CW1'(1);
        w_in_window = 1'b0;
        w_lock_inc  = (r_lock_cnt >= LOCK_TGT) ? LOCK_TGT : r_lock_cnt + CNT_W'(1);
        case (r_state)
            IDLE:    w_compare = w_ref_edge & w_fb_edge;
            UP:      w_compare = w_fb_edge;
            DOWN:    w_compare = w_ref_edge;
            default: w_compare = 1'b0;
        endcase
        if (r_state == IDLE) w_in_window = 1'b1;
        else                 w_in_window = (w_width <= CW1'(LOCK_WINDOW));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_cnt <= '0;
            r_lock     <= 1'b0;
        end else if (scan_en) begin
            r_lock_cnt <= {r_lock_cnt[CNT_W-2:0], r_width_cnt[CNT_W-1]};
            r_lock     <= r_lock_cnt[CNT_W-1];
        end else if (w_compare) begin
            if (w_in_window) begin
                r_lock_cnt <= w_lock_inc;
                r_lock     <= (w_lock_inc == LOCK_TGT);
            end else begin
                r_lock_cnt <= '0;
                r_lock     <= 1'b0;
            end
        end
    end

    assign lock     = r_lock;
    assign scan_out = r_lock;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = |{CW1'(LOCK_WINDOW), CW1'(LOCK_COUNT)};
    assign lock         = 1'b0;
    assign scan_out     = r_width_cnt[CNT_W-1];
`endif

endmodule

// File: tb/tb_pfd_tristate.sv
// Directed + randomized bench for pfd_tristate against a leader/timestamp reference model.
module tb_pfd_tristate;
    import pll_pkg::*;

`ifdef PFD_LOCK_DETECT_EN
    localparam bit LD    = 1'b1;
    localparam int CHAIN = 19;
`else
    localparam bit LD    = 1'b0;
    localparam int CHAIN = 10;
`endif
    localparam int WIN  = 4;
    localparam int LCNT = 64;

    logic clk, rst_n, ref_in, fb_in, scan_in, scan_en;
    logic up, down, lock, scan_out;

    pfd_tristate dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ref_in   (ref_in),
        .fb_in    (fb_in),
        .up       (up),
        .down     (down),
        .lock     (lock),
        .scan_in  (scan_in),
        .scan_en  (scan_en),
        .scan_out (scan_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: who leads (+1 ref, -1 fb, 0 none) and when the lead began.
    int m_lead, m_start, m_step, m_lock_cnt;
    bit m_lock, m_pr, m_pf;
    bit q_up[$], q_dn[$], q_lk[$];
    int run_up, run_dn, exp_pw;
    bit sbits [0:2*CHAIN-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_compare(input int w);
        if (w <= WIN) m_lock_cnt = (m_lock_cnt + 1 > LCNT) ? LCNT : m_lock_cnt + 1;
        else          m_lock_cnt = 0;
        m_lock = LD && (m_lock_cnt == LCNT);
    endfunction

    function automatic void model_step(input bit r, input bit f);
        bit rr, ff;
        rr = r && !m_pr;
        ff = f && !m_pf;
        m_pr = r;
        m_pf = f;
        if (m_lead == 0) begin
            if (rr && ff)  m_compare(0);
            else if (rr) begin m_lead = 1;  m_start = m_step; end
            else if (ff) begin m_lead = -1; m_start = m_step; end
        end else if ((m_lead == 1 && ff) || (m_lead == -1 && rr)) begin
            m_compare(m_step - m_start);
            m_lead = 0;
        end
        m_step++;
        q_up.push_back(m_lead == 1);
        q_dn.push_back(m_lead == -1);
        q_lk.push_back(m_lock);
    endfunction

    task automatic model_reset();
        m_lead = 0; m_start = 0; m_step = 0; m_lock_cnt = 0;
        m_lock = 1'b0; m_pr = 1'b0; m_pf = 1'b0;
        q_up.delete(); q_dn.delete(); q_lk.delete();
        repeat (3) begin q_up.push_back(1'b0); q_dn.push_back(1'b0); end
        repeat (2) q_lk.push_back(1'b0);
        run_up = 0; run_dn = 0;
    endtask

    task automatic tick();
        bit eu, ed, el;
        @(posedge clk);
        model_step(ref_in, fb_in);
        #1;
        eu = q_up.pop_front();
        ed = q_dn.pop_front();
        el = q_lk.pop_front();
        chk("up", 32'(up), 32'(eu));
        chk("down", 32'(down), 32'(ed));
        chk("lock", 32'(lock), 32'(el));
        if (up === 1'b1) run_up++;
        else begin
            if (run_up > 0 && exp_pw >= 0) chk("up_width", run_up, exp_pw);
            run_up = 0;
        end
        if (down === 1'b1) run_dn++;
        else begin
            if (run_dn > 0 && exp_pw >= 0) chk("down_width", run_dn, exp_pw);
            run_dn = 0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ref_in = 1'b0; fb_in = 1'b0; scan_en = 1'b0; scan_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic run_wave(input int period, input int ro, input int fo, input int hi,
                            input int n, input int pw);
        exp_pw = pw;
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < period; c++) begin
                ref_in = (((c - ro + period) % period) < hi);
                fb_in  = (((c - fo + period) % period) < hi);
                tick();
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; ref_in = 1'b0; fb_in = 1'b0; scan_en = 1'b0; scan_in = 1'b0;
        exp_pw = -1;
        #12;
        chk("rst_up", 32'(up), 0);
        chk("rst_down", 32'(down), 0);
        chk("rst_lock", 32'(lock), 0);
        chk("rst_scan_out", 32'(scan_out), 0);
        do_reset();
        repeat (4) tick();

        // Reference leads by 6: out-of-window pulses, never locks.
        run_wave(40, 0, 6, 20, 10, 6);
        chk("lead6_lock", 32'(lock), 0);

        // Feedback leads by 3: in-window, lock after 64 pulses; one 10-cycle error clears it.
        run_wave(40, 3, 0, 20, 66, 3);
        chk("lead3_lock", 32'(lock), 32'(LD));
        run_wave(40, 10, 0, 20, 1, 10);
        chk("err_lock", 32'(lock), 0);

        // Coincident edges: width-0 comparisons only.
        run_wave(40, 0, 0, 20, 66, -1);
        chk("coinc_lock", 32'(lock), 32'(LD));

        // Feedback stuck low: up stays high and the width counter saturates.
        exp_pw = -1;
        fb_in  = 1'b0;
        for (int c = 0; c < 500; c++) begin
            ref_in = ((c % 20) < 10);
            tick();
            if (c == 300) chk("wsat_300", 32'(dut.r_width_cnt), 255);
        end
        chk("wsat_500", 32'(dut.r_width_cnt), 255);
        chk("sat_up", 32'(up), 1);

        // Asynchronous reset mid-pulse.
        rst_n = 1'b0;
        #1;
        chk("arst_up", 32'(up), 0);
        chk("arst_down", 32'(down), 0);
        chk("arst_lock", 32'(lock), 0);
        do_reset();

        // Randomized phase relationships.
        for (int p = 0; p < 25; p++)
            run_wave(40, int'($urandom_range(0, 39)), int'($urandom_range(0, 39)),
                     int'($urandom_range(2, 30)), 1, -1);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) ref_in = ~ref_in;
            if ($urandom_range(0, 2) == 0) fb_in  = ~fb_in;
            tick();
        end

        // Scan chain: pattern emerges CHAIN cycles later.
        do_reset();
        repeat (3) tick();
        for (int j = 0; j < 2 * CHAIN; j++) sbits[j] = 1'($urandom_range(0, 1));
        for (int j = 0; j < 2 * CHAIN; j++) begin
            scan_en = 1'b1;
            scan_in = sbits[j];
            @(posedge clk);
            #1;
            chk("scan_out", 32'(scan_out), (j + 1 < CHAIN) ? 0 : 32'(sbits[j + 1 - CHAIN]));
        end

        // Illegal state loaded by scan recovers to IDLE with outputs low.
        scan_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("scan_load11", 32'(dut.r_state), 3);
        scan_en = 1'b0;
        scan_in = 1'b0;
        @(posedge clk);
        #1;
        chk("illegal_state", 32'(dut.r_state), 0);
        chk("illegal_up", 32'(up), 0);
        chk("illegal_down", 32'(down), 0);
        @(posedge clk);
        #1;
        chk("illegal_up2", 32'(up), 0);
        chk("illegal_down2", 32'(down), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pfd_tristate.md
# pfd_tristate

Digital tri-state phase-frequency detector that generates the `up`/`down` pulse pair consumed by the PLL loop filter. It samples asynchronous reference and feedback clocks on the system clock and outputs registered, mutually exclusive up/down pulses whose width in `clk` cycles equals the phase error. It also provides an optional lock detector and joins the scan chain.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth per input, ≥2.
- `CNT_W`, 8: width of pulse-width and lock counters.
- `LOCK_WINDOW`, 4: maximum pulse width, in cycles, that counts as in-window.
- `LOCK_COUNT`, 64: number of consecutive in-window comparisons required for lock; must be ≤ 2^CNT_W−1.

Ports:
- `clk`  in  1  sampling clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ref_in`  in  1  reference clock, asynchronous to `clk`.
- `fb_in`  in  1  divided feedback clock, asynchronous to `clk`.
- `up`  out  1  registered; high while the reference leads.
- `down`  out  1  registered; high while the feedback leads.
- `lock`  out  1  registered lock indication.
- `scan_in`  in  1  scan chain input.
- `scan_en`  in  1  scan shift enable.
- `scan_out`  out  1  scan chain output.

## Operation
- Each input passes through `SYNC_STAGES` flops and then one delay flop. `edge = sync & ~sync_d`, which detects rising edges only.
- FSM states: IDLE, UP, DOWN.
  - IDLE: `ref_edge & ~fb_edge` → UP. `fb_edge & ~ref_edge` → DOWN. Both edges together → stay in IDLE; this is a width-0 comparison.
  - UP: `fb_edge` → IDLE. A further `ref_edge` is ignored and the FSM stays in UP.
  - DOWN: mirrors UP.
  - Illegal encoding 2'b11 (reachable only via scan) → IDLE on the next functional cycle, with outputs low.
- `up = (state==UP)`, `down = (state==DOWN)`. They are never both 1.
- `width_cnt`:
  - Cleared while in IDLE.
  - Increments every cycle in UP or DOWN.
  - Saturates at 2^CNT_W−1 and never wraps.
- A comparison occurs on every transition into IDLE, and on both-edge events in IDLE. It is in-window when the width is ≤ `LOCK_WINDOW`. The width is the count of cycles `up`/`down` was high.
- Lock detect: see Configuration.
- Scan (`scan_en=1`):
  - Chain order: `scan_in` → `state[0]` → `state[1]` → `width_cnt[0..CNT_W-1]` → `lock_cnt[0..CNT_W-1]` (when compiled in) → `lock` (when compiled in) → `scan_out`.
  - Synchronizer and delay flops keep sampling but are not on the chain.
  - The FSM and counters only shift. Edges arriving during scan are lost.

## Timing
- Reset values: state IDLE, all counters 0, `up=down=lock=scan_out=0`, synchronizer flops 0.
- Latency: an input rise captured by the first sync flop at edge N produces the `up`/`down` change at edge N+SYNC_STAGES+1 (N+3 by default). Removal of `up` on the opposing edge has the same latency.
- Output pulse width equals the synchronized edge separation, with ±1 cycle sampling uncertainty.
- Input high and low phases must each last ≥2 `clk` periods. Shorter pulses may be missed.
- `lock` updates on the same edge the FSM enters IDLE.
- Reset asserted mid-pulse drops `up`/`down`/`lock` asynchronously. After release, the first edge restarts from IDLE.

## Configuration
- `PFD_LOCK_DETECT_EN` defined:
  - `lock_cnt` (CNT_W bits) increments on each in-window comparison and saturates at `LOCK_COUNT`.
  - `lock` = 1 when `lock_cnt == LOCK_COUNT`.
  - An out-of-window comparison clears `lock_cnt` and `lock` on that edge.
- Undefined: `lock` is tied 0, `lock_cnt` is absent, and the chain ends at `width_cnt[CNT_W-1]`.

## Structure
- Package `pll_pkg`: `pfd_state_t` enum (IDLE=2'b00, UP=2'b01, DOWN=2'b10) and default parameter constants.
- Sub-module `edge_sync` (synchronizer + delay flop + rising-edge output), instantiated once for `ref_in` and once for `fb_in`.

## Test plan
- Reference leads by 6 cycles, period 40 → `up` high exactly 6 cycles per period, `down`=0, `lock` stays 0 (macro on).
- Feedback leads by 3 cycles → `down` high 3 cycles per period. `lock` rises at the end of the 64th pulse, and a single 10-cycle error pulse clears it on the edge that ends that pulse.
- Coincident edges for 64 periods → `up=down=0` throughout, `lock=1` after the 64th comparison.
- `fb_in` held low, `ref_in` toggling → `up` stays high and `width_cnt` saturates at 255 without wrapping. Reset mid-pulse → all outputs 0 immediately.
- Scan, macro on: shift 19 bits (2 state + 8 width + 8 lock + 1 `lock`) with `scan_en=1`; the pattern appears on `scan_out` delayed by 19 cycles. Load state 2'b11, drop `scan_en` → IDLE and `up=down=0` next cycle.
- Macro off: repeat the first scenario → `lock` is 0 throughout and the chain length is 10.
